// File: rtl/smc_seq_collector_if.sv
// Item/result bus for the MOSFET current/transconductance collector.
// Valid-only handshake: items in, one pulsed 10-bit result out.
interface smc_seq_collector_if;
  logic       in_valid;
  logic [1:0] mode;
  logic [2:0] W;
  logic [2:0] V_GS;
  logic [2:0] V_DS;
  logic       out_valid;
  logic [9:0] out_n;

  modport master (
    output in_valid, mode, W, V_GS, V_DS,
    input  out_valid, out_n
  );

  modport slave (
    input  in_valid, mode, W, V_GS, V_DS,
    output out_valid, out_n
  );
endinterface

// File: rtl/smc_seq_collector.sv
// Serial collector: six MOSFET items in, running top/bottom-3 list,
// then a divided and weighted 10-bit result pulsed out.
module smc_seq_collector (
  input  logic clk,
  input  logic rst,
  smc_seq_collector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CALC,
    OUT
  } state_t;

  state_t     state, state_nx;
  logic [2:0] count, count_nx;
  logic [1:0] mode_q, mode_nx;
  logic [7:0] r0, r1, r2;
  logic [7:0] r0_nx, r1_nx, r2_nx;
  logic [9:0] out_q, out_nx;

  // The first item of a batch uses the live mode and a fresh list.
  logic [1:0] mode_eff;
  logic [7:0] b0, b1, b2;
  logic [7:0] init_v;
  logic [2:0] base_cnt;

  assign mode_eff = (state == IDLE) ? bus.mode : mode_q;
  assign init_v   = mode_eff[1] ? 8'h00 : 8'hFF;
  assign b0       = (state == IDLE) ? init_v : r0;
  assign b1       = (state == IDLE) ? init_v : r1;
  assign b2       = (state == IDLE) ? init_v : r2;
  assign base_cnt = (state == IDLE) ? 3'd0 : count;

  // Per-item I/G value.
  logic [2:0]  ov;
  logic        triode;
  logic [3:0]  two_ov_m;
  logic [7:0]  inner;
  logic [2:0]  gsel;
  logic [10:0] i_full;
  logic [7:0]  g_full;
  logic [7:0]  val;

  assign ov       = bus.V_GS - 3'd1;
  assign triode   = ov > bus.V_DS;
  assign two_ov_m = {ov, 1'b0} - {1'b0, bus.V_DS};
  assign inner    = triode
                  ? ({5'd0, bus.V_DS} * {4'd0, two_ov_m})
                  : ({5'd0, ov} * {5'd0, ov});
  assign gsel     = triode ? bus.V_DS : ov;
  assign i_full   = {8'd0, bus.W} * {3'd0, inner};
  assign g_full   = {5'd0, bus.W} * {4'd0, gsel, 1'b0};
  assign val      = mode_eff[0] ? i_full[7:0] : g_full;

  // Sorted insertion of the new value into r0 >= r1 >= r2.
  logic [7:0] i0, i1, i2;

  always_comb begin
    i0 = b0;
    i1 = b1;
    i2 = b2;
    if (mode_eff[1]) begin
      if (val > b0) begin
        i0 = val; i1 = b0; i2 = b1;
      end else if (val > b1) begin
        i1 = val; i2 = b1;
      end else if (val > b2) begin
        i2 = val;
      end
    end else if (base_cnt < 3'd3 || val < b0) begin
      if (val >= b1) begin
        i0 = val;
      end else if (val >= b2) begin
        i0 = b1; i1 = val;
      end else begin
        i0 = b1; i1 = b2; i2 = val;
      end
    end
  end

  // Divide-by-3 and weighting of the kept three.
  logic [9:0] d0, d1, d2;
  logic [9:0] sum;

  assign d0  = {2'd0, r0} / 10'd3;
  assign d1  = {2'd0, r1} / 10'd3;
  assign d2  = {2'd0, r2} / 10'd3;
  assign sum = mode_q[0]
             ? (10'd3 * d0 + 10'd4 * d1 + 10'd5 * d2)
             : (d0 + d1 + d2);

  // Next-state and datapath updates.
  always_comb begin
    state_nx = state;
    count_nx = count;
    mode_nx  = mode_q;
    r0_nx    = r0;
    r1_nx    = r1;
    r2_nx    = r2;
    out_nx   = '0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          mode_nx  = bus.mode;
          r0_nx    = i0;
          r1_nx    = i1;
          r2_nx    = i2;
          count_nx = 3'd1;
          state_nx = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.in_valid) begin
          r0_nx    = i0;
          r1_nx    = i1;
          r2_nx    = i2;
          count_nx = count + 3'd1;
          if (count == 3'd5) state_nx = CALC;
        end
      end
      CALC: begin
        out_nx   = sum;
        state_nx = OUT;
      end
      OUT: begin
        count_nx = 3'd0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= 3'd0;
      mode_q <= 2'd0;
      r0     <= 8'd0;
      r1     <= 8'd0;
      r2     <= 8'd0;
      out_q  <= 10'd0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      mode_q <= mode_nx;
      r0     <= r0_nx;
      r1     <= r1_nx;
      r2     <= r2_nx;
      out_q  <= out_nx;
    end
  end

  assign bus.out_valid = (state == OUT);
  assign bus.out_n     = out_q;

endmodule

// File: tb/tb_smc_seq_collector.sv
// Bench for smc_seq_collector: directed plan scenarios plus random
// batches checked against a sort-based reference model.
module tb_smc_seq_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;

  smc_seq_collector_if ifc();

  smc_seq_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int pulses = 0;

  int         it_w[6];
  int         it_g[6];
  int         it_d[6];
  logic [1:0] it_m[6];

  // One cycle: move to the next falling edge and tally output pulses.
  task automatic step();
    @(negedge clk);
    if (ifc.out_valid === 1'b1) pulses++;
  endtask

  function automatic int item_val(int w, int vgs, int vds, bit sel_i);
    int ov, i, g;
    ov = (vgs + 7) % 8;
    if (ov > vds) begin
      i = w * (2 * ov * vds - vds * vds);
      g = w * 2 * vds;
    end else begin
      i = w * ov * ov;
      g = w * 2 * ov;
    end
    return sel_i ? (i % 256) : (g % 256);
  endfunction

  function automatic int model_out();
    int v[6];
    int t, a, b, c;
    for (int k = 0; k < 6; k++)
      v[k] = item_val(it_w[k], it_g[k], it_d[k], it_m[0][0]);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 5 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    if (it_m[0][1]) begin
      a = v[5] / 3; b = v[4] / 3; c = v[3] / 3;
    end else begin
      a = v[2] / 3; b = v[1] / 3; c = v[0] / 3;
    end
    if (it_m[0][0]) return 3 * a + 4 * b + 5 * c;
    return a + b + c;
  endfunction

  task automatic set_all(int w, int g, int d, logic [1:0] m);
    for (int k = 0; k < 6; k++) begin
      it_w[k] = w; it_g[k] = g; it_d[k] = d; it_m[k] = m;
    end
  endtask

  task automatic set_mixed(logic [1:0] m);
    it_w = '{7, 1, 1, 0, 2, 1};
    it_g = '{7, 3, 0, 5, 3, 2};
    it_d = '{7, 1, 3, 2, 1, 0};
    for (int k = 0; k < 6; k++) it_m[k] = m;
  endtask

  task automatic set_random();
    it_m[0] = 2'($urandom_range(0, 3));
    for (int k = 0; k < 6; k++) begin
      it_w[k] = $urandom_range(0, 7);
      it_g[k] = $urandom_range(0, 7);
      it_d[k] = $urandom_range(0, 7);
      if (k > 0) it_m[k] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic drive_item(int k);
    ifc.in_valid = 1'b1;
    ifc.mode     = it_m[k];
    ifc.W        = 3'(it_w[k]);
    ifc.V_GS     = 3'(it_g[k]);
    ifc.V_DS     = 3'(it_d[k]);
  endtask

  // Sends the loaded batch and checks the CALC/OUT timing and value.
  task automatic do_batch(string name, int exp, int max_gap,
                          bit junk, bit tail);
    int p0, gap;
    p0 = pulses;
    for (int k = 0; k < 6; k++) begin
      if (k > 0 && max_gap > 0) begin
        gap = $urandom_range(0, max_gap);
        repeat (gap) begin
          step();
          ifc.in_valid = 1'b0;
        end
      end
      step();
      drive_item(k);
    end
    step();
    total++;
    if (pulses !== p0 || ifc.out_valid !== 1'b0)
      $display("FAIL %s early_pulse: pulses=%0d valid=%b want %0d/0",
               name, pulses - p0, ifc.out_valid, 0);
    else passed++;
    if (junk) begin
      ifc.in_valid = 1'b1;
      ifc.mode     = 2'd3;
      ifc.W        = 3'd7;
      ifc.V_GS     = 3'd7;
      ifc.V_DS     = 3'd7;
    end else begin
      ifc.in_valid = 1'b0;
    end
    step();
    ifc.in_valid = 1'b0;
    total++;
    if (ifc.out_valid !== 1'b1)
      $display("FAIL %s out_valid: got %b want 1", name, ifc.out_valid);
    else passed++;
    total++;
    if (ifc.out_n !== 10'(exp))
      $display("FAIL %s out_n: got %0d want %0d", name, ifc.out_n, exp);
    else passed++;
    if (tail) begin
      step();
      total++;
      if (ifc.out_valid !== 1'b0 || ifc.out_n !== 10'd0)
        $display("FAIL %s after_out: valid=%b n=%0d want 0/0",
                 name, ifc.out_valid, ifc.out_n);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    repeat (3) step();
    total++;
    if (ifc.out_valid !== 1'b0)
      $display("FAIL reset_valid: got %b want 0", ifc.out_valid);
    else passed++;
    total++;
    if (ifc.out_n !== 10'd0)
      $display("FAIL reset_n: got %0d want 0", ifc.out_n);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_uniform();
    set_all(7, 7, 7, 2'd3);
    do_batch("uni_m3", 1008, 0, 0, 1);
    set_all(7, 7, 7, 2'd2);
    do_batch("uni_m2", 84, 0, 0, 1);
    set_all(7, 7, 7, 2'd0);
    do_batch("uni_m0", 84, 0, 0, 1);
  endtask

  task automatic test_mixed();
    set_mixed(2'd3);
    do_batch("mix_m3", 306, 0, 0, 1);
    set_mixed(2'd1);
    do_batch("mix_m1", 3, 0, 0, 1);
  endtask

  task automatic test_gaps();
    set_mixed(2'd3);
    for (int k = 1; k < 6; k++) it_m[k] = 2'($urandom_range(0, 3));
    do_batch("gap_m3", 306, 3, 0, 1);
    set_mixed(2'd1);
    for (int k = 1; k < 6; k++) it_m[k] = 2'($urandom_range(0, 3));
    do_batch("gap_m1", 3, 3, 0, 1);
  endtask

  task automatic test_abort();
    int p0;
    p0 = pulses;
    set_mixed(2'd3);
    for (int k = 0; k < 4; k++) begin
      step();
      drive_item(k);
    end
    step();
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    total++;
    if (pulses !== p0)
      $display("FAIL abort_pulse: got %0d want 0", pulses - p0);
    else passed++;
    set_all(7, 7, 7, 2'd3);
    do_batch("abort_next", 1008, 0, 0, 1);
  endtask

  task automatic test_trunc();
    set_all(7, 0, 7, 2'd3);
    do_batch("trunc", 348, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    set_random();
    do_batch("b2b_1", model_out(), 0, 1, 0);
    set_mixed(2'd1);
    do_batch("b2b_2", 3, 0, 0, 0);
    set_random();
    do_batch("b2b_3", model_out(), 1, 0, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      set_random();
      do_batch($sformatf("rand%0d", n), model_out(),
               $urandom_range(0, 2), n[0], n[1] | n[2]);
    end
    step();
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.mode     = 2'd0;
    ifc.W        = 3'd0;
    ifc.V_GS     = 3'd0;
    ifc.V_DS     = 3'd0;
    test_reset();
    test_uniform();
    test_mixed();
    test_gaps();
    test_abort();
    test_trunc();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
